// File: rtl/id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage
//   ID/EX pipeline register plus the EX-side operand select feeding the ALU.
//   Decoded operands and control are captured each cycle. stall holds them
//   and flush loads a bubble; flush wins over stall. With forwarding enabled,
//   RAW hazards are resolved from the EX/MEM and MEM/WB stages. EX/MEM has
//   priority, and register 0 is never forwarded.
//
// Configuration macro:
//   ID_EX_FORWARD_EN - defined  : forwarding muxes on operands a and rt.
//                      undefined: fwd_*_sel tied to 00, operands come straight
//                                 from the stored register-file data, and the
//                                 exmem_* / memwb_* inputs are ignored.
//
// Ports:
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   stall, flush           hold current contents / load a bubble
//   id_*                   decoded instruction from the ID stage
//   exmem_*, memwb_*       destination / write-enable / value of later stages
//   alu_a, alu_b           ALU operands (b = imm when alu_src is set)
//   alu_c_in, alu_operation ALU control taken from the stored fields
//   ex_rt_data             forwarded rt value (store data)
//   ex_rd, ex_reg_write    destination and write-enable carried to EX/MEM
//   ex_valid               EX slot holds a real instruction
//   fwd_a_sel, fwd_b_sel   00 register file, 01 MEM/WB, 10 EX/MEM
// ---------------------------------------------------------------------------
module id_ex_operand_stage #(
  parameter int W = 32,
  parameter int A = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         flush,
  input  logic         id_valid,
  input  logic [W-1:0] id_rs_data,
  input  logic [W-1:0] id_rt_data,
  input  logic [W-1:0] id_imm,
  input  logic [A-1:0] id_rs_addr,
  input  logic [A-1:0] id_rt_addr,
  input  logic [A-1:0] id_rd_addr,
  input  logic [2:0]   id_alu_op,
  input  logic         id_c_in,
  input  logic         id_alu_src,
  input  logic         id_reg_write,
  input  logic [A-1:0] exmem_rd,
  input  logic         exmem_reg_write,
  input  logic [W-1:0] exmem_result,
  input  logic [A-1:0] memwb_rd,
  input  logic         memwb_reg_write,
  input  logic [W-1:0] memwb_result,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic         alu_c_in,
  output logic [2:0]   alu_operation,
  output logic [W-1:0] ex_rt_data,
  output logic [A-1:0] ex_rd,
  output logic         ex_reg_write,
  output logic         ex_valid,
  output logic [1:0]   fwd_a_sel,
  output logic [1:0]   fwd_b_sel
);

  typedef struct packed {
    logic         valid;
    logic [W-1:0] rs_data;
    logic [W-1:0] rt_data;
    logic [W-1:0] imm;
    logic [A-1:0] rs_addr;
    logic [A-1:0] rt_addr;
    logic [A-1:0] rd_addr;
    logic [2:0]   alu_op;
    logic         c_in;
    logic         alu_src;
    logic         reg_write;
  } id_ex_t;

  id_ex_t ex_d, ex_q;

  logic [W-1:0] rs_fwd;
  logic [W-1:0] rt_fwd;

  // Next-state select: flush beats stall, stall beats capture.
  always_comb begin
    // NOTE: assign a default first so every path drives ex_d; otherwise a latch is inferred.
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (!stall) begin
      ex_d.valid     = id_valid;
      ex_d.rs_data   = id_rs_data;
      ex_d.rt_data   = id_rt_data;
      ex_d.imm       = id_imm;
      ex_d.rs_addr   = id_rs_addr;
      ex_d.rt_addr   = id_rt_addr;
      ex_d.rd_addr   = id_rd_addr;
      ex_d.alu_op    = id_alu_op;
      ex_d.c_in      = id_c_in;
      ex_d.alu_src   = id_alu_src;
      // A bubble must never write the register file.
      ex_d.reg_write = id_reg_write & id_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

`ifdef ID_EX_FORWARD_EN
  // The selects are evaluated live on the held addresses, so during a stall
  // the operands still track newly arriving EX/MEM and MEM/WB values.
  always_comb begin
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (ex_q.valid) begin
      if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_q.rs_addr)) begin
        fwd_a_sel = 2'b10;
      end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_q.rs_addr)) begin
        fwd_a_sel = 2'b01;
      end
      if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_q.rt_addr)) begin
        fwd_b_sel = 2'b10;
      end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_q.rt_addr)) begin
        fwd_b_sel = 2'b01;
      end
    end
  end

  always_comb begin
    case (fwd_a_sel)
      2'b10:   rs_fwd = exmem_result;
      2'b01:   rs_fwd = memwb_result;
      default: rs_fwd = ex_q.rs_data;
    endcase
    case (fwd_b_sel)
      2'b10:   rt_fwd = exmem_result;
      2'b01:   rt_fwd = memwb_result;
      default: rt_fwd = ex_q.rt_data;
    endcase
  end
`else
  // Without forwarding, the hazard unit or software inserts the stalls; the
  // later-stage inputs and stored source indices are deliberately ignored.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{exmem_rd, exmem_reg_write, exmem_result,
                               memwb_rd, memwb_reg_write, memwb_result,
                               ex_q.rs_addr, ex_q.rt_addr};

  assign fwd_a_sel = 2'b00;
  assign fwd_b_sel = 2'b00;
  assign rs_fwd    = ex_q.rs_data;
  assign rt_fwd    = ex_q.rt_data;
`endif

  assign alu_a         = rs_fwd;
  assign alu_b         = ex_q.alu_src ? ex_q.imm : rt_fwd;
  assign ex_rt_data    = rt_fwd;
  assign alu_c_in      = ex_q.c_in;
  assign alu_operation = ex_q.alu_op;
  assign ex_rd         = ex_q.rd_addr;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_valid      = ex_q.valid;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_operand_stage
//   Directed bench for id_ex_operand_stage. Each step drives the ID and
//   forwarding inputs, pushes the expected output set to a queue, and pops
//   it once the DUT output is due (#1 after the edge, or #1 after a purely
//   combinational change). Expected operand values depend on whether
//   ID_EX_FORWARD_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_id_ex_operand_stage;

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [2:0]  id_alu_op;
  logic        id_c_in, id_alu_src, id_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_reg_write, memwb_reg_write;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_a, alu_b, ex_rt_data;
  logic        alu_c_in;
  logic [2:0]  alu_operation;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_valid;
  logic [1:0]  fwd_a_sel, fwd_b_sel;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rt;
    logic        c_in;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic        rw;
    logic        valid;
    logic [1:0]  sa;
    logic [1:0]  sb;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  id_ex_operand_stage #(.W(32), .A(5)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .flush           (flush),
    .id_valid        (id_valid),
    .id_rs_data      (id_rs_data),
    .id_rt_data      (id_rt_data),
    .id_imm          (id_imm),
    .id_rs_addr      (id_rs_addr),
    .id_rt_addr      (id_rt_addr),
    .id_rd_addr      (id_rd_addr),
    .id_alu_op       (id_alu_op),
    .id_c_in         (id_c_in),
    .id_alu_src      (id_alu_src),
    .id_reg_write    (id_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .exmem_result    (exmem_result),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_result    (memwb_result),
    .alu_a           (alu_a),
    .alu_b           (alu_b),
    .alu_c_in        (alu_c_in),
    .alu_operation   (alu_operation),
    .ex_rt_data      (ex_rt_data),
    .ex_rd           (ex_rd),
    .ex_reg_write    (ex_reg_write),
    .ex_valid        (ex_valid),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic check_field(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] rs_d, input logic [31:0] rt_d,
                        input logic [31:0] imm, input logic [2:0] op, input logic cin,
                        input logic src, input logic rw);
    id_valid     = v;
    id_rs_addr   = rs;
    id_rt_addr   = rt;
    id_rd_addr   = rd;
    id_rs_data   = rs_d;
    id_rt_data   = rt_d;
    id_imm       = imm;
    id_alu_op    = op;
    id_c_in      = cin;
    id_alu_src   = src;
    id_reg_write = rw;
  endtask

  task automatic set_fwd(input logic [4:0] em_rd, input logic em_rw, input logic [31:0] em_res,
                         input logic [4:0] mw_rd, input logic mw_rw, input logic [31:0] mw_res);
    exmem_rd        = em_rd;
    exmem_reg_write = em_rw;
    exmem_result    = em_res;
    memwb_rd        = mw_rd;
    memwb_reg_write = mw_rw;
    memwb_result    = mw_res;
  endtask

  task automatic expect_out(input logic [31:0] a, input logic [31:0] b, input logic [31:0] rt,
                            input logic cin, input logic [2:0] op, input logic [4:0] rd,
                            input logic rw, input logic v, input logic [1:0] sa,
                            input logic [1:0] sb);
    exp_t e;
    e.a = a; e.b = b; e.rt = rt; e.c_in = cin; e.op = op;
    e.rd = rd; e.rw = rw; e.valid = v; e.sa = sa; e.sb = sb;
    exp_q.push_back(e);
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      failed++;
      $display("FAIL %s: observed empty scoreboard, expected a queued entry", tag);
      return;
    end
    e = exp_q.pop_front();
    check_field({tag, ".alu_a"},         alu_a,                 e.a);
    check_field({tag, ".alu_b"},         alu_b,                 e.b);
    check_field({tag, ".ex_rt_data"},    ex_rt_data,            e.rt);
    check_field({tag, ".alu_c_in"},      {31'd0, alu_c_in},     {31'd0, e.c_in});
    check_field({tag, ".alu_operation"}, {29'd0, alu_operation}, {29'd0, e.op});
    check_field({tag, ".ex_rd"},         {27'd0, ex_rd},        {27'd0, e.rd});
    check_field({tag, ".ex_reg_write"},  {31'd0, ex_reg_write}, {31'd0, e.rw});
    check_field({tag, ".ex_valid"},      {31'd0, ex_valid},     {31'd0, e.valid});
    check_field({tag, ".fwd_a_sel"},     {30'd0, fwd_a_sel},    {30'd0, e.sa});
    check_field({tag, ".fwd_b_sel"},     {30'd0, fwd_b_sel},    {30'd0, e.sb});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    #1;
    expect_out(0, 0, 0, 0, 3'd0, 0, 0, 0, 2'b00, 2'b00);
    check_pop("reset");

    // Valid add captured, then asynchronous reset between edges
    set_id(1, 5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 0, 3'b000, 1, 0, 1);
    #1 rst_n = 1'b1;
    expect_out(32'd5, 32'd7, 32'd7, 1, 3'b000, 5'd4, 1, 1, 2'b00, 2'b00);
    tick();
    check_pop("add_capture");
    #2 rst_n = 1'b0;
    expect_out(0, 0, 0, 0, 3'd0, 0, 0, 0, 2'b00, 2'b00);
    #1;
    check_pop("reset_mid");
    rst_n = 1'b1;

    // Plain capture, first edge after reset release
    set_id(1, 5'd1, 5'd2, 5'd5, 32'h10, 32'h20, 0, 3'b010, 0, 0, 1);
    expect_out(32'h10, 32'h20, 32'h20, 0, 3'b010, 5'd5, 1, 1, 2'b00, 2'b00);
    tick();
    check_pop("plain");

    // Double hazard: EX/MEM wins, then MEM/WB once EX/MEM stops writing
    set_id(1, 5'd3, 5'd3, 5'd8, 32'h3, 32'h33, 0, 3'b010, 0, 0, 1);
    set_fwd(5'd3, 1, 32'hAAAA, 5'd3, 1, 32'hBBBB);
    expect_out(FWD_EN ? 32'hAAAA : 32'h3, FWD_EN ? 32'hAAAA : 32'h33,
               FWD_EN ? 32'hAAAA : 32'h33, 0, 3'b010, 5'd8, 1, 1,
               FWD_EN ? 2'b10 : 2'b00, FWD_EN ? 2'b10 : 2'b00);
    tick();
    check_pop("hazard_exmem");
    exmem_reg_write = 1'b0;
    expect_out(FWD_EN ? 32'hBBBB : 32'h3, FWD_EN ? 32'hBBBB : 32'h33,
               FWD_EN ? 32'hBBBB : 32'h33, 0, 3'b010, 5'd8, 1, 1,
               FWD_EN ? 2'b01 : 2'b00, FWD_EN ? 2'b01 : 2'b00);
    #1;
    check_pop("hazard_memwb");

    // Register 0 is never forwarded
    set_id(1, 5'd0, 5'd6, 5'd9, 32'h77, 32'h66, 0, 3'b001, 0, 0, 1);
    set_fwd(5'd0, 1, 32'hFFFF, 5'd0, 0, 0);
    expect_out(32'h77, 32'h66, 32'h66, 0, 3'b001, 5'd9, 1, 1, 2'b00, 2'b00);
    tick();
    check_pop("reg0");

    // Immediate path: b is imm, store data still forwarded
    set_id(1, 5'd8, 5'd7, 5'd12, 32'h22, 32'h11, 32'hFFFF_FFFC, 3'b011, 1, 1, 1);
    set_fwd(5'd7, 1, 32'h55, 5'd0, 0, 0);
    expect_out(32'h22, 32'hFFFF_FFFC, FWD_EN ? 32'h55 : 32'h11, 1, 3'b011, 5'd12, 1, 1,
               2'b00, FWD_EN ? 2'b10 : 2'b00);
    tick();
    check_pop("imm");

    // Invalid slot: no forwarding, reg_write masked
    set_id(0, 5'd7, 5'd7, 5'd13, 32'h99, 32'h88, 0, 3'b100, 0, 0, 1);
    expect_out(32'h99, 32'h88, 32'h88, 0, 3'b100, 5'd13, 0, 0, 2'b00, 2'b00);
    tick();
    check_pop("invalid");

    // Stall for two cycles while ID changes; forwarding stays live on held addresses
    set_id(1, 5'd9, 5'd10, 5'd11, 32'h1234, 32'h5678, 0, 3'b101, 1, 0, 1);
    set_fwd(0, 0, 0, 0, 0, 0);
    expect_out(32'h1234, 32'h5678, 32'h5678, 1, 3'b101, 5'd11, 1, 1, 2'b00, 2'b00);
    tick();
    check_pop("pre_stall");
    stall = 1'b1;
    set_id(1, 5'd1, 5'd2, 5'd14, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h1, 3'b110, 0, 0, 0);
    expect_out(32'h1234, 32'h5678, 32'h5678, 1, 3'b101, 5'd11, 1, 1, 2'b00, 2'b00);
    tick();
    check_pop("stall1");
    set_fwd(0, 0, 0, 5'd9, 1, 32'hCAFE);
    expect_out(FWD_EN ? 32'hCAFE : 32'h1234, 32'h5678, 32'h5678, 1, 3'b101, 5'd11, 1, 1,
               FWD_EN ? 2'b01 : 2'b00, 2'b00);
    tick();
    check_pop("stall2_live_fwd");

    // Flush wins over stall
    flush = 1'b1;
    expect_out(0, 0, 0, 0, 3'd0, 0, 0, 0, 2'b00, 2'b00);
    tick();
    check_pop("flush_over_stall");

    // Release: capture resumes with the pending ID inputs
    stall = 1'b0;
    flush = 1'b0;
    expect_out(32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h0BAD_F00D, 0, 3'b110, 5'd14, 0, 1,
               2'b00, 2'b00);
    tick();
    check_pop("resume");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
